// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: the hex glyph table used by both the
// encoder and the capture decoder, plus the capture FSM state type.
package seg7_pkg;

   localparam int SEG7_W = 7;
   localparam int CNT_W  = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Glyphs for nibbles F..0, bit6..bit0 = g..a, 1 = segment lit.
   localparam logic [15:0][SEG7_W-1:0] SEG7_LUT = {
      7'h71, 7'h79, 7'h5E, 7'h58, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   typedef enum logic [1:0] {
      CAP_IDLE   = 2'd0,
      CAP_SETTLE = 2'd1,
      CAP_HELD   = 2'd2
   } cap_state_t;

   function automatic logic [SEG7_W-1:0] seg7_encode(input logic [3:0] nibble);
      return SEG7_LUT[nibble];
   endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational reverse lookup of a polarity-corrected segment pattern
// into a hex nibble; hit is low for any pattern outside the glyph table.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [SEG7_W-1:0] seg,
   output logic              hit,
   output logic [3:0]        nibble
);

   always_comb begin
      hit    = 1'b0;
      nibble = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (!hit && (seg == SEG7_LUT[i])) begin
            hit    = 1'b1;
            nibble = 4'(i);
         end
      end
   end

endmodule

// File: rtl/seg_to_hex_capture.sv
// Receive-side capture of a scanned seven-segment bus: waits for each
// digit's pattern to dwell STABLE_CYCLES edges, then commits its hex value.
module seg_to_hex_capture
   import seg7_pkg::*;
#(
   parameter int DIGITS        = 6,
   parameter int STABLE_CYCLES = 4,
   localparam int IDX_W        = (DIGITS > 1) ? $clog2(DIGITS) : 1
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [SEG7_W-1:0]     seg_in,
   input  logic [DIGITS-1:0]     digit_sel,
   input  logic                  negate,
   output logic [DIGITS*4-1:0]   hex_vec,
   output logic [DIGITS-1:0]     digit_valid,
   output logic                  frame_valid,
   output logic                  upd_pulse,
   output logic                  err_pulse,
   output logic [IDX_W-1:0]      err_digit
);

   localparam logic [CNT_W-1:0] COMMIT_CNT = CNT_W'(STABLE_CYCLES - 1);

   logic [SEG7_W-1:0] seg_n;
   logic              sample_ok;
   logic              same_sample;
   logic              commit;
   logic              dec_hit;
   logic [3:0]        dec_nibble;
   logic [IDX_W-1:0]  sel_idx;

   cap_state_t        state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [DIGITS-1:0] prev_sel_reg, prev_sel_next;
   logic [SEG7_W-1:0] prev_seg_reg, prev_seg_next;

   logic [3:0]        hex_reg [DIGITS];
   logic              valid_reg [DIGITS];
   logic              frame_valid_reg;
   logic              upd_pulse_reg;
   logic              err_pulse_reg;
   logic [IDX_W-1:0]  err_digit_reg;

   assign seg_n       = seg_in ^ {SEG7_W{negate}};
   assign sample_ok   = $onehot(digit_sel);
   assign same_sample = (digit_sel == prev_sel_reg) && (seg_n == prev_seg_reg);

   seg7_pattern_decode u_decode (
      .seg    (seg_n),
      .hit    (dec_hit),
      .nibble (dec_nibble)
   );

   always_comb begin
      sel_idx = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (digit_sel[i]) begin
            sel_idx = IDX_W'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= CAP_IDLE;
         cnt_reg      <= '0;
         prev_sel_reg <= '0;
         prev_seg_reg <= '0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         prev_sel_reg <= prev_sel_next;
         prev_seg_reg <= prev_seg_next;
      end
   end

   // An invalid select always abandons the dwell; any change of select or
   // polarity-corrected pattern restarts it at a count of one.
   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      prev_sel_next = prev_sel_reg;
      prev_seg_next = prev_seg_reg;
      commit        = 1'b0;

      if (!sample_ok) begin
         state_next    = CAP_IDLE;
         cnt_next      = '0;
         prev_sel_next = '0;
         prev_seg_next = '0;
      end else begin
         prev_sel_next = digit_sel;
         prev_seg_next = seg_n;
         case (state_reg)
            CAP_IDLE: begin
               state_next = CAP_SETTLE;
               cnt_next   = CNT_W'(1);
            end
            CAP_SETTLE: begin
               if (same_sample) begin
                  cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
                  if (cnt_reg == COMMIT_CNT) begin
                     commit     = 1'b1;
                     state_next = CAP_HELD;
                  end
               end else begin
                  cnt_next = CNT_W'(1);
               end
            end
            CAP_HELD: begin
               if (same_sample) begin
                  cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
               end else begin
                  state_next = CAP_SETTLE;
                  cnt_next   = CNT_W'(1);
               end
            end
            default: begin
               state_next = CAP_IDLE;
               cnt_next   = '0;
            end
         endcase
      end
   end

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               hex_reg[gi]   <= 4'd0;
               valid_reg[gi] <= 1'b0;
            end else if (commit && digit_sel[gi]) begin
               // An illegal glyph keeps the last good nibble but marks it stale.
               if (dec_hit) begin
                  hex_reg[gi] <= dec_nibble;
               end
               valid_reg[gi] <= dec_hit;
            end
         end

         assign hex_vec[gi*4 +: 4] = hex_reg[gi];
         assign digit_valid[gi]    = valid_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_valid_reg <= 1'b0;
         upd_pulse_reg   <= 1'b0;
         err_pulse_reg   <= 1'b0;
         err_digit_reg   <= '0;
      end else begin
         frame_valid_reg <= &digit_valid;
         upd_pulse_reg   <= commit && dec_hit;
         err_pulse_reg   <= commit && !dec_hit;
         if (commit && !dec_hit) begin
            err_digit_reg <= sel_idx;
         end
      end
   end

   assign frame_valid = frame_valid_reg;
   assign upd_pulse   = upd_pulse_reg;
   assign err_pulse   = err_pulse_reg;
   assign err_digit   = err_digit_reg;

endmodule

// File: tb/tb_seg_to_hex_capture.sv
// Bench for seg_to_hex_capture: directed test-plan steps plus random bursts,
// each edge checked against a run-length reference model.
module tb_seg_to_hex_capture;

   localparam int DIGITS = 6;
   localparam int STABLE = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  seg_in;
   logic [5:0]  digit_sel;
   logic        negate;
   logic [23:0] hex_vec;
   logic [5:0]  digit_valid;
   logic        frame_valid;
   logic        upd_pulse;
   logic        err_pulse;
   logic [2:0]  err_digit;

   seg_to_hex_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seg_in      (seg_in),
      .digit_sel   (digit_sel),
      .negate      (negate),
      .hex_vec     (hex_vec),
      .digit_valid (digit_valid),
      .frame_valid (frame_valid),
      .upd_pulse   (upd_pulse),
      .err_pulse   (err_pulse),
      .err_digit   (err_digit)
   );

   always #5 clk = ~clk;

   logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71};

   int checks = 0;
   int errors = 0;
   int n_upd  = 0;
   int n_err  = 0;

   // Reference model: the length of the current run of identical one-hot
   // samples; a digit is taken exactly when its run reaches STABLE.
   logic [3:0] m_hex [DIGITS];
   logic       m_valid [DIGITS];
   logic       m_frame, m_upd, m_err;
   logic [2:0] m_err_digit;
   int         m_run;
   logic [5:0] m_last_sel;
   logic [6:0] m_last_seg;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input logic [5:0] sel, input logic [6:0] seg,
                             input logic neg, input logic rst);
      logic [6:0] s;
      logic       all_ok;
      int         idx;
      int         found;
      if (!rst) begin
         for (int i = 0; i < DIGITS; i++) begin
            m_hex[i]   = 4'd0;
            m_valid[i] = 1'b0;
         end
         m_frame = 0; m_upd = 0; m_err = 0; m_err_digit = 0;
         m_run = 0; m_last_sel = 0; m_last_seg = 0;
         return;
      end
      all_ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) all_ok = all_ok & m_valid[i];
      m_frame = all_ok;
      m_upd = 0;
      m_err = 0;
      s = seg ^ {7{neg}};
      if ($countones(sel) != 1) begin
         m_run = 0;
      end else begin
         if (m_run > 0 && sel == m_last_sel && s == m_last_seg) m_run++;
         else m_run = 1;
         m_last_sel = sel;
         m_last_seg = s;
         if (m_run == STABLE) begin
            idx = 0;
            for (int i = 0; i < DIGITS; i++) if (sel[i]) idx = i;
            found = -1;
            for (int v = 0; v < 16; v++) if (glyph[v] == s) found = v;
            if (found >= 0) begin
               m_hex[idx]   = 4'(found);
               m_valid[idx] = 1'b1;
               m_upd        = 1'b1;
            end else begin
               m_valid[idx] = 1'b0;
               m_err        = 1'b1;
               m_err_digit  = 3'(idx);
            end
         end
      end
   endtask

   task automatic tick(input logic [5:0] sel, input logic [6:0] seg,
                       input logic neg, input logic rst);
      logic [23:0] exp_hex;
      logic [5:0]  exp_valid;
      digit_sel = sel;
      seg_in    = seg;
      negate    = neg;
      rst_n     = rst;
      @(posedge clk);
      model_edge(sel, seg, neg, rst);
      #1;
      for (int i = 0; i < DIGITS; i++) begin
         exp_hex[i*4 +: 4] = m_hex[i];
         exp_valid[i]      = m_valid[i];
      end
      chk("model_hex_vec", 32'(hex_vec), 32'(exp_hex));
      chk("model_digit_valid", 32'(digit_valid), 32'(exp_valid));
      chk("model_frame_valid", 32'(frame_valid), 32'(m_frame));
      chk("model_upd_pulse", 32'(upd_pulse), 32'(m_upd));
      chk("model_err_pulse", 32'(err_pulse), 32'(m_err));
      chk("model_err_digit", 32'(err_digit), 32'(m_err_digit));
      if (upd_pulse === 1'b1) n_upd++;
      if (err_pulse === 1'b1) n_err++;
   endtask

   task automatic show(input int d, input logic [6:0] lit, input logic neg, input int n);
      for (int c = 0; c < n; c++) tick(6'(1) << d, lit ^ {7{neg}}, neg, 1'b1);
   endtask

   task automatic scan(input logic [23:0] val, input logic neg);
      for (int d = 0; d < DIGITS; d++) show(d, glyph[val[d*4 +: 4]], neg, 6);
   endtask

   logic [5:0] r_sel;
   logic [6:0] r_lit;
   logic       r_neg, r_n2;
   int         r_d, r_len, r_kind;

   initial begin
      // Reset with random inputs
      for (int c = 0; c < 2; c++) tick(6'($urandom), 7'($urandom), 1'($urandom), 1'b0);
      chk("reset_hex_vec", 32'(hex_vec), 32'h0);
      chk("reset_digit_valid", 32'(digit_valid), 32'h0);
      chk("reset_frame_valid", 32'(frame_valid), 32'h0);
      chk("reset_pulses", 32'({upd_pulse, err_pulse}), 32'h0);
      chk("reset_err_digit", 32'(err_digit), 32'h0);

      // Round trip, active-high bus
      scan(24'h1A2B3C, 1'b0);
      chk("rt_hex_vec", 32'(hex_vec), 32'h1A2B3C);
      chk("rt_digit_valid", 32'(digit_valid), 32'h3F);
      show(5, glyph[1], 1'b0, 1);
      chk("rt_frame_valid", 32'(frame_valid), 32'h1);

      // Round trip, inverted bus, from reset
      tick(6'h01, 7'h00, 1'b0, 1'b0);
      scan(24'h1A2B3C, 1'b1);
      chk("rtn_hex_vec", 32'(hex_vec), 32'h1A2B3C);
      chk("rtn_digit_valid", 32'(digit_valid), 32'h3F);
      show(5, glyph[1], 1'b1, 1);
      chk("rtn_frame_valid", 32'(frame_valid), 32'h1);

      // Glitch reject on digit 2
      n_upd = 0;
      show(2, 7'h3F, 1'b0, 3);
      show(2, 7'h06, 1'b0, 4);
      chk("glitch_upd_count", 32'(n_upd), 32'd1);
      chk("glitch_hex_digit2", 32'(hex_vec[11:8]), 32'h1);

      // Illegal pattern on digit 4
      n_err = 0;
      show(4, 7'h40, 1'b0, 3);
      chk("illegal_no_early_err", 32'(n_err), 32'd0);
      show(4, 7'h40, 1'b0, 1);
      chk("illegal_err_pulse", 32'(err_pulse), 32'h1);
      chk("illegal_err_digit", 32'(err_digit), 32'd4);
      chk("illegal_valid4", 32'(digit_valid[4]), 32'h0);
      chk("illegal_hex4_kept", 32'(hex_vec[19:16]), 32'hA);
      show(4, 7'h40, 1'b0, 1);
      chk("illegal_pulse_width", 32'(err_pulse), 32'h0);
      chk("illegal_frame_drop", 32'(frame_valid), 32'h0);

      // Bad select: multi-hot and none
      n_upd = 0; n_err = 0;
      for (int c = 0; c < 10; c++) tick(6'b000011, 7'h3F, 1'b0, 1'b1);
      for (int c = 0; c < 10; c++) tick(6'b000000, 7'h06, 1'b0, 1'b1);
      chk("badsel_no_pulses", 32'(n_upd + n_err), 32'd0);
      chk("badsel_hex_vec", 32'(hex_vec), 32'h1A213C);
      chk("badsel_digit_valid", 32'(digit_valid), 32'h2F);

      // Reset mid-dwell
      n_upd = 0;
      show(0, glyph[7], 1'b0, 3);
      tick(6'h01, glyph[7], 1'b0, 1'b0);
      show(0, glyph[7], 1'b0, 3);
      chk("rstdwell_no_commit", 32'(n_upd), 32'd0);
      show(0, glyph[7], 1'b0, 1);
      chk("rstdwell_commit", 32'(n_upd), 32'd1);
      chk("rstdwell_hex_vec", 32'(hex_vec), 32'h000007);
      chk("rstdwell_digit_valid", 32'(digit_valid), 32'h01);

      // Random bursts
      for (int b = 0; b < 120; b++) begin
         r_d    = $urandom_range(0, DIGITS - 1);
         r_len  = $urandom_range(1, 7);
         r_kind = $urandom_range(0, 9);
         r_neg  = 1'($urandom_range(0, 1));
         r_sel  = 6'(1) << r_d;
         r_lit  = glyph[$urandom_range(0, 15)];
         if (r_kind == 0) r_sel = 6'($urandom_range(0, 63));
         if (r_kind == 1) r_lit = 7'($urandom);
         for (int c = 0; c < r_len; c++) begin
            r_n2 = r_neg;
            if (r_kind == 2 && c == r_len / 2) r_n2 = ~r_neg;
            tick(r_sel, r_lit ^ {7{r_neg}}, r_n2, 1'b1);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_to_hex_capture.md
# seg_to_hex_capture

Sequential decoder for a multiplexed seven-segment display bus: the receive-side counterpart of the hex-to-7seg encoder. It samples a scanned segment bus plus one-hot digit select, waits for each digit's pattern to be stable, and reverse-maps it to a hex nibble with per-digit validity and error reporting. It sits in loopback/self-check paths and bench monitors, reconstructing the hex value driven onto the display.

## Interface
- DIGITS, 6, number of scanned digits (1..16)
- STABLE_CYCLES, 4, consecutive identical samples required before commit (2..255)
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- seg_in  in  7  segment lines, bit0=a … bit6=g (1 = lit after polarity correction)
- digit_sel  in  DIGITS  digit select, active high, must be one-hot to be sampled
- negate  in  1  1 = segment bus is active-low; seg_in is XORed with {7{negate}} before decode
- hex_vec  out  DIGITS*4  decoded nibbles, digit i at [i*4 +: 4]
- digit_valid  out  DIGITS  digit i holds a legally decoded nibble
- frame_valid  out  1  registered AND of all digit_valid bits
- upd_pulse  out  1  one-cycle pulse on every legal commit
- err_pulse  out  1  one-cycle pulse on every illegal-pattern commit
- err_digit  out  $clog2(DIGITS) (min 1)  index of the last digit that raised err_pulse

## Operation
- Normalise: seg_n = seg_in ^ {7{negate}}.
- Sample valid when digit_sel is exactly one-hot; zero or multi-hot select is an invalid sample.
- Internal regs: prev_sel, prev_seg, cnt (8 bit, saturating), state.
- State machine:
  - IDLE: no valid dwell. Valid sample -> SETTLE, cnt=1.
  - SETTLE: sample equals prev (sel and seg_n) -> cnt+1; when cnt==STABLE_CYCLES-1 and the match holds, commit this edge -> HELD. Different valid sample -> restart SETTLE, cnt=1. Invalid sample -> IDLE, cnt=0.
  - HELD: matching sample -> stay, no further commit. Different valid sample -> SETTLE, cnt=1. Invalid sample -> IDLE.
- Commit of digit i (i = index of digit_sel bit):
  - seg_n matches one of the 16 table patterns (0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 B:7C C:58 D:5E E:79 F:71, hex of bit6..0): hex_vec[i]<=nibble, digit_valid[i]<=1, upd_pulse<=1.
  - Otherwise (including blank 00): hex_vec[i] unchanged, digit_valid[i]<=0, err_pulse<=1, err_digit<=i.
- Exactly one commit per dwell; a re-commit of the same digit with the same value still pulses upd_pulse.
- negate toggling mid-dwell changes seg_n and restarts the dwell like any pattern change.

## Timing
- Reset (rst_n low at edge): hex_vec=0, digit_valid=0, frame_valid=0, upd_pulse=0, err_pulse=0, err_digit=0, state=IDLE, cnt=0, prev_sel=0, prev_seg=0. Reset mid-dwell discards the dwell; no commit.
- Latency: pattern stable on input for STABLE_CYCLES consecutive rising edges -> hex_vec/digit_valid/pulses update at the STABLE_CYCLES-th edge.
- frame_valid lags digit_valid by one cycle.
- Glitches shorter than STABLE_CYCLES edges produce no output change.
- Pulses are high for exactly one cycle; back-to-back commits (STABLE_CYCLES=2, digit change every 2 cycles) yield pulses every 2 cycles.
- cnt saturates at 255; no wrap.

## Structure
- Shared package seg7_pkg: SEG7_LUT constant (16 x 7-bit patterns above), SEG7_W=7 localparam. The existing encoder and this block use the same table.
- Sub-module seg7_pattern_decode: combinational seg_n -> {hit, nibble} reverse lookup over SEG7_LUT.
- Top holds sampling registers, FSM, and per-digit output registers.

## Test plan
- Reset: drive rst_n=0 for 2 cycles with random inputs -> all outputs 0; frame_valid=0.
- Round trip: encoder drives 24'h1A2B3C, negate=0, each digit held 6 cycles, full scan -> hex_vec=24'h1A2B3C, digit_valid=6'h3F, frame_valid next cycle; repeat with negate=1 and inverted bus -> same result.
- Glitch reject: digit 2 stable 3F for 3 cycles (STABLE_CYCLES=4), then 06 for 4 cycles -> single upd_pulse, hex_vec[11:8]=1, no commit of 0.
- Illegal pattern: digit 4 shows 7'h40 for 4 cycles -> err_pulse one cycle, err_digit=4, digit_valid[4]=0, hex_vec[19:16] unchanged, frame_valid drops next cycle.
- Bad select: digit_sel=6'b000011 or 0 with legal pattern for 10 cycles -> no pulses, outputs unchanged.
- Reset mid-dwell: 3 of 4 stable cycles, rst_n low one cycle, 1 more identical cycle -> no commit; commit only after 4 further stable cycles.
